// File: rtl/ap_ctrl_txn_monitor.sv
// Per-channel ap_ctrl_hs transaction monitor: latency/iteration/stall statistics and sticky protocol errors.
// rd_data appears one cycle after rd_ch/rd_sel; busy/all_idle are combinational; pure observer, never stalls.
module ap_ctrl_txn_monitor #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ap_start,
  input  logic [NUM_CH-1:0] ap_done,
  input  logic [NUM_CH-1:0] ap_continue,
  input  logic [NUM_CH-1:0] iter_pulse,
  input  logic              clear,
  input  logic [2:0]        rd_ch,
  input  logic [2:0]        rd_sel,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] proto_err,
  output logic              all_idle
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e           state_q     [NUM_CH];
  state_e           state_d     [NUM_CH];
  logic [CNT_W-1:0] lat_cnt_q   [NUM_CH];
  logic [CNT_W-1:0] lat_cnt_d   [NUM_CH];
  logic [CNT_W-1:0] iter_cnt_q  [NUM_CH];
  logic [CNT_W-1:0] iter_cnt_d  [NUM_CH];
  logic [CNT_W-1:0] txn_count_q [NUM_CH];
  logic [CNT_W-1:0] txn_count_d [NUM_CH];
  logic [CNT_W-1:0] last_lat_q  [NUM_CH];
  logic [CNT_W-1:0] last_lat_d  [NUM_CH];
  logic [CNT_W-1:0] min_lat_q   [NUM_CH];
  logic [CNT_W-1:0] min_lat_d   [NUM_CH];
  logic [CNT_W-1:0] max_lat_q   [NUM_CH];
  logic [CNT_W-1:0] max_lat_d   [NUM_CH];
  logic [CNT_W-1:0] last_iter_q [NUM_CH];
  logic [CNT_W-1:0] last_iter_d [NUM_CH];
  logic [CNT_W-1:0] hold_cyc_q  [NUM_CH];
  logic [CNT_W-1:0] hold_cyc_d  [NUM_CH];
  logic [NUM_CH-1:0] proto_err_q;
  logic [NUM_CH-1:0] proto_err_d;
  logic [CNT_W-1:0]  rd_data_q;
  logic [CNT_W-1:0]  rd_data_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // FSM state register
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (!reset) state_q[i] <= ST_IDLE;
      else        state_q[i] <= state_d[i];
    end
  end

  // A done outside RUN is a protocol error and freezes the channel for that cycle.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (!ap_done[i] && ap_start[i]) state_d[i] = ST_RUN;
        end
        ST_RUN: begin
          if (ap_done[i]) begin
            if (!ap_continue[i])   state_d[i] = ST_HOLD;
            else if (!ap_start[i]) state_d[i] = ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (!ap_done[i] && ap_continue[i]) state_d[i] = ap_start[i] ? ST_RUN : ST_IDLE;
        end
        default: state_d[i] = ST_IDLE;
      endcase
    end
  end

  // FSM status outputs
  always_comb begin
    busy = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      busy[i] = (state_q[i] != ST_IDLE);
    end
    all_idle = ~|busy;
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      lat_cnt_d[i]   = lat_cnt_q[i];
      iter_cnt_d[i]  = iter_cnt_q[i];
      txn_count_d[i] = txn_count_q[i];
      last_lat_d[i]  = last_lat_q[i];
      min_lat_d[i]   = min_lat_q[i];
      max_lat_d[i]   = max_lat_q[i];
      last_iter_d[i] = last_iter_q[i];
      hold_cyc_d[i]  = hold_cyc_q[i];
    end
    proto_err_d = proto_err_q;

    for (int i = 0; i < NUM_CH; i++) begin
      // Entering RUN, or back-to-back restart, begins a fresh measurement.
      if (state_d[i] == ST_RUN && (state_q[i] != ST_RUN || ap_done[i])) begin
        lat_cnt_d[i]  = CNT_ONE;
        iter_cnt_d[i] = CNT_ZERO;
      end else if (state_q[i] == ST_RUN && !ap_done[i]) begin
        lat_cnt_d[i] = sat_inc(lat_cnt_q[i]);
        if (iter_pulse[i]) iter_cnt_d[i] = sat_inc(iter_cnt_q[i]);
      end

      if (state_q[i] == ST_RUN && ap_done[i]) begin
        txn_count_d[i] = sat_inc(txn_count_q[i]);
        last_lat_d[i]  = lat_cnt_q[i];
        if (lat_cnt_q[i] < min_lat_q[i]) min_lat_d[i] = lat_cnt_q[i];
        if (lat_cnt_q[i] > max_lat_q[i]) max_lat_d[i] = lat_cnt_q[i];
        last_iter_d[i] = iter_pulse[i] ? sat_inc(iter_cnt_q[i]) : iter_cnt_q[i];
      end

      if (state_q[i] == ST_HOLD && !ap_done[i]) hold_cyc_d[i] = sat_inc(hold_cyc_q[i]);

      if (state_q[i] != ST_RUN && ap_done[i]) proto_err_d[i] = 1'b1;

      // Clear overrides any coincident recording; live measurement is untouched.
      if (clear) begin
        txn_count_d[i] = CNT_ZERO;
        last_lat_d[i]  = CNT_ZERO;
        min_lat_d[i]   = CNT_MAX;
        max_lat_d[i]   = CNT_ZERO;
        last_iter_d[i] = CNT_ZERO;
        hold_cyc_d[i]  = CNT_ZERO;
      end
    end
  end

  always_comb begin
    rd_data_d = CNT_ZERO;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == 3'(i)) begin
        case (rd_sel)
          3'd0:    rd_data_d = txn_count_q[i];
          3'd1:    rd_data_d = last_lat_q[i];
          3'd2:    rd_data_d = min_lat_q[i];
          3'd3:    rd_data_d = max_lat_q[i];
          3'd4:    rd_data_d = last_iter_q[i];
          3'd5:    rd_data_d = hold_cyc_q[i];
          3'd6:    rd_data_d = {{(CNT_W-3){1'b0}}, state_q[i], proto_err_q[i]};
          default: rd_data_d = CNT_ZERO;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        lat_cnt_q[i]   <= CNT_ZERO;
        iter_cnt_q[i]  <= CNT_ZERO;
        txn_count_q[i] <= CNT_ZERO;
        last_lat_q[i]  <= CNT_ZERO;
        min_lat_q[i]   <= CNT_MAX;
        max_lat_q[i]   <= CNT_ZERO;
        last_iter_q[i] <= CNT_ZERO;
        hold_cyc_q[i]  <= CNT_ZERO;
      end
      proto_err_q <= '0;
      rd_data_q   <= CNT_ZERO;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        lat_cnt_q[i]   <= lat_cnt_d[i];
        iter_cnt_q[i]  <= iter_cnt_d[i];
        txn_count_q[i] <= txn_count_d[i];
        last_lat_q[i]  <= last_lat_d[i];
        min_lat_q[i]   <= min_lat_d[i];
        max_lat_q[i]   <= max_lat_d[i];
        last_iter_q[i] <= last_iter_d[i];
        hold_cyc_q[i]  <= hold_cyc_d[i];
      end
      proto_err_q <= proto_err_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_ap_ctrl_txn_monitor.sv
// Directed bench for ap_ctrl_txn_monitor; readout expectations queue up when a read is issued
// and are compared against rd_data one cycle later.
module tb_ap_ctrl_txn_monitor;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] ap_start;
  logic [NUM_CH-1:0] ap_done;
  logic [NUM_CH-1:0] ap_continue;
  logic [NUM_CH-1:0] iter_pulse;
  logic              clear;
  logic [2:0]        rd_ch;
  logic [2:0]        rd_sel;
  logic [CNT_W-1:0]  rd_data;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] proto_err;
  logic              all_idle;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string            tag;
    logic [CNT_W-1:0] exp;
  } rd_exp_t;

  rd_exp_t sb[$];

  ap_ctrl_txn_monitor #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .ap_start    (ap_start),
    .ap_done     (ap_done),
    .ap_continue (ap_continue),
    .iter_pulse  (iter_pulse),
    .clear       (clear),
    .rd_ch       (rd_ch),
    .rd_sel      (rd_sel),
    .rd_data     (rd_data),
    .busy        (busy),
    .proto_err   (proto_err),
    .all_idle    (all_idle)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1 time unit later, retire any pending readout expectation.
  task automatic tick();
    rd_exp_t e;
    @(posedge clock);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, 64'(rd_data), 64'(e.exp));
    end
  endtask

  task automatic rd_req(input logic [2:0] ch, input logic [2:0] sel,
                        input logic [CNT_W-1:0] exp, input string tag);
    rd_exp_t e;
    rd_ch  = ch;
    rd_sel = sel;
    e.tag  = tag;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic rd(input logic [2:0] ch, input logic [2:0] sel,
                    input logic [CNT_W-1:0] exp, input string tag);
    rd_req(ch, sel, exp, tag);
    tick();
  endtask

  initial begin
    reset       = 1'b0;
    ap_start    = '0;
    ap_done     = '0;
    ap_continue = '1;
    iter_pulse  = '0;
    clear       = 1'b0;
    rd_ch       = 3'd0;
    rd_sel      = 3'd0;
    repeat (3) tick();
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_all_idle", 64'(all_idle), 64'h1);
    chk("rst_proto_err", 64'(proto_err), 64'h0);
    chk("rst_rd_data", 64'(rd_data), 64'h0);
    reset = 1'b1;
    tick();
    rd(3'd0, 3'd2, 8'hFF, "rst_min_lat");
    rd(3'd0, 3'd0, 8'h00, "rst_txn");

    // Single transaction on ch0: latency 5, three iterations.
    ap_start[0] = 1'b1; tick(); ap_start[0] = 1'b0;
    chk("t1_busy_run", 64'(busy[0]), 64'h1);
    iter_pulse[0] = 1'b1; tick(); tick(); tick(); iter_pulse[0] = 1'b0;
    tick();
    chk("t1_busy_pre_done", 64'(busy[0]), 64'h1);
    ap_done[0] = 1'b1; tick(); ap_done[0] = 1'b0;
    chk("t1_busy_post_done", 64'(busy[0]), 64'h0);
    chk("t1_all_idle", 64'(all_idle), 64'h1);
    rd(3'd0, 3'd0, 8'd1, "t1_txn");
    rd(3'd0, 3'd1, 8'd5, "t1_last_lat");
    rd(3'd0, 3'd2, 8'd5, "t1_min_lat");
    rd(3'd0, 3'd3, 8'd5, "t1_max_lat");
    rd(3'd0, 3'd4, 8'd3, "t1_last_iter");
    rd(3'd0, 3'd6, 8'd0, "t1_state");
    rd(3'd0, 3'd7, 8'd0, "t1_sel7");

    // Back-to-back on ch1: latencies 3 then 2, never idle in between.
    ap_start[1] = 1'b1; tick(); ap_start[1] = 1'b0;
    tick(); tick();
    ap_done[1] = 1'b1; ap_start[1] = 1'b1; tick(); ap_done[1] = 1'b0; ap_start[1] = 1'b0;
    chk("t2_busy_b2b", 64'(busy[1]), 64'h1);
    tick();
    chk("t2_busy_b2b_2", 64'(busy[1]), 64'h1);
    ap_done[1] = 1'b1; tick(); ap_done[1] = 1'b0;
    chk("t2_busy_end", 64'(busy[1]), 64'h0);
    rd(3'd1, 3'd0, 8'd2, "t2_txn");
    rd(3'd1, 3'd1, 8'd2, "t2_last_lat");
    rd(3'd1, 3'd2, 8'd2, "t2_min_lat");
    rd(3'd1, 3'd3, 8'd3, "t2_max_lat");

    // Continue stall on ch2: four HOLD cycles, early start ignored.
    ap_start[2] = 1'b1; tick(); ap_start[2] = 1'b0;
    tick();
    ap_done[2] = 1'b1; ap_continue[2] = 1'b0; tick(); ap_done[2] = 1'b0;
    ap_start[2] = 1'b1; tick(); tick();
    rd_req(3'd2, 3'd6, 8'h04, "t3_state_hold"); tick();
    chk("t3_busy_hold", 64'(busy[2]), 64'h1);
    ap_continue[2] = 1'b1; tick();
    ap_start[2] = 1'b0;
    rd_req(3'd2, 3'd6, 8'h02, "t3_state_run"); tick();
    ap_done[2] = 1'b1; tick(); ap_done[2] = 1'b0;
    rd(3'd2, 3'd5, 8'd4, "t3_hold_cyc");
    rd(3'd2, 3'd0, 8'd2, "t3_txn");
    rd(3'd2, 3'd1, 8'd2, "t3_last_lat");
    chk("t3_proto_err", 64'(proto_err[2]), 64'h0);
    chk("t3_busy_end", 64'(busy[2]), 64'h0);

    // Protocol error on idle ch3, sticky across clear.
    ap_done[3] = 1'b1; tick(); ap_done[3] = 1'b0;
    chk("t4_proto_err", 64'(proto_err), 64'h8);
    chk("t4_busy", 64'(busy[3]), 64'h0);
    rd(3'd3, 3'd0, 8'd0, "t4_txn");
    rd(3'd3, 3'd6, 8'd1, "t4_state_perr");
    clear = 1'b1; tick(); clear = 1'b0;
    chk("t4_perr_after_clear", 64'(proto_err[3]), 64'h1);
    rd(3'd0, 3'd0, 8'd0,  "clr_txn_ch0");
    rd(3'd0, 3'd2, 8'hFF, "clr_min_ch0");
    rd(3'd2, 3'd5, 8'd0,  "clr_hold_ch2");
    rd(3'd1, 3'd3, 8'd0,  "clr_max_ch1");

    // Clear coinciding with done: cleared values win.
    ap_start[1] = 1'b1; tick(); ap_start[1] = 1'b0;
    ap_done[1] = 1'b1; clear = 1'b1; tick(); ap_done[1] = 1'b0; clear = 1'b0;
    chk("clr_done_busy", 64'(busy[1]), 64'h0);
    rd(3'd1, 3'd0, 8'd0,  "clr_done_txn");
    rd(3'd1, 3'd2, 8'hFF, "clr_done_min");

    // 300 one-cycle transactions on ch0 saturate txn_count at 255.
    ap_start[0] = 1'b1; tick();
    ap_done[0] = 1'b1;
    repeat (299) tick();
    ap_start[0] = 1'b0; tick(); ap_done[0] = 1'b0;
    chk("sat_busy", 64'(busy[0]), 64'h0);
    rd(3'd0, 3'd0, 8'hFF, "sat_txn");
    rd(3'd0, 3'd1, 8'd1,  "sat_last_lat");
    rd(3'd0, 3'd2, 8'd1,  "sat_min_lat");
    rd(3'd0, 3'd3, 8'd1,  "sat_max_lat");

    // Clear during RUN: in-flight latency survives, stats restart.
    ap_start[0] = 1'b1; tick(); ap_start[0] = 1'b0;
    tick();
    clear = 1'b1; tick(); clear = 1'b0;
    tick();
    ap_done[0] = 1'b1; tick(); ap_done[0] = 1'b0;
    rd(3'd0, 3'd0, 8'd1, "clr_run_txn");
    rd(3'd0, 3'd1, 8'd4, "clr_run_last_lat");
    rd(3'd0, 3'd2, 8'd4, "clr_run_min_lat");
    rd(3'd0, 3'd3, 8'd4, "clr_run_max_lat");

    // Out-of-range readout.
    rd(3'd7, 3'd0, 8'd0, "rd_ch7");
    rd(3'd4, 3'd2, 8'd0, "rd_ch4");

    // Reset mid-RUN discards the in-flight transaction.
    ap_start[1] = 1'b1; tick(); ap_start[1] = 1'b0;
    tick();
    chk("rst_mid_busy_pre", 64'(busy[1]), 64'h1);
    rd_ch = 3'd0; rd_sel = 3'd0;
    reset = 1'b0; tick();
    chk("rst_mid_all_idle", 64'(all_idle), 64'h1);
    chk("rst_mid_busy", 64'(busy), 64'h0);
    chk("rst_mid_rd_data", 64'(rd_data), 64'h0);
    chk("rst_mid_perr", 64'(proto_err), 64'h0);
    reset = 1'b1;
    ap_done[1] = 1'b1; tick(); ap_done[1] = 1'b0;
    chk("rst_late_done_perr", 64'(proto_err), 64'h2);
    rd(3'd1, 3'd0, 8'd0,  "rst_mid_txn_ch1");
    rd(3'd1, 3'd2, 8'hFF, "rst_mid_min_ch1");
    rd(3'd0, 3'd0, 8'd0,  "rst_mid_txn_ch0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ap_ctrl_txn_monitor.md
AP_CTRL_TXN_MONITOR -- requirements
Module: ap_ctrl_txn_monitor

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, giving the number of monitored ap_ctrl_hs channels (legal range 1..8).
REQ-002 The block SHALL have parameter CNT_W, default 32, giving the width of every counter and of rd_data (legal range 8..64).
REQ-003 clock  input  1  the single clock; all logic SHALL be rising-edge.
REQ-004 reset  input  1  reset, synchronous and active-low (0 = reset).
REQ-005 ap_start  input  NUM_CH  per-channel start, sampled each cycle.
REQ-006 ap_done  input  NUM_CH  per-channel done pulse.
REQ-007 ap_continue  input  NUM_CH  per-channel continue; tie to 1 for channels without one.
REQ-008 iter_pulse  input  NUM_CH  one-cycle pulse at each loop-iteration end state.
REQ-009 clear  input  1  synchronous statistics clear.
REQ-010 rd_ch  input  3  readout channel select.
REQ-011 rd_sel  input  3  readout counter select.
REQ-012 rd_data  output  CNT_W  selected counter, registered.
REQ-013 busy  output  NUM_CH  channel not in IDLE.
REQ-014 proto_err  output  NUM_CH  sticky protocol-error flags.
REQ-015 all_idle  output  1  all channels in IDLE.

Function
REQ-016 Each channel SHALL run an independent FSM with states IDLE, RUN and HOLD.
REQ-017 IDLE with ap_start=1 SHALL go to RUN and load lat_cnt=1 and iter_cnt=0.
REQ-018 In RUN with ap_done=0: lat_cnt SHALL increment (saturating); iter_cnt SHALL increment (saturating) on iter_pulse.
REQ-019 In RUN with ap_done=1, the channel SHALL record the completed transaction as follows.
- txn_count++ (saturating).
- last_lat=lat_cnt; min_lat=min(min_lat,lat_cnt); max_lat=max(max_lat,lat_cnt).
- last_iter=iter_cnt, plus 1 if iter_pulse is set in the same cycle.
REQ-020 Timing definition: start sampled in cycle t and done in cycle t+L SHALL record latency L (minimum 1).
REQ-021 RUN with ap_done=1 SHALL select the next state as follows.
- ap_continue=0: HOLD.
- ap_continue=1 and ap_start=0: IDLE.
- ap_continue=1 and ap_start=1: stay in RUN, reload lat_cnt=1 and iter_cnt=0 (back-to-back transaction).
REQ-022 In HOLD, hold_cyc SHALL increment (saturating) each cycle; ap_continue=1 SHALL exit to IDLE, or to RUN (lat_cnt=1) if ap_start=1 in the same cycle.
REQ-023 ap_done=1 in IDLE or HOLD SHALL set proto_err for that channel, with no state or counter change; the flag SHALL clear only on reset.
REQ-024 Saturation: every counter SHALL hold at 2^CNT_W-1 and never wrap.
REQ-025 clear=1 SHALL zero txn_count, last_lat, max_lat, last_iter and hold_cyc, and set min_lat to all-ones, for every channel.
- FSM state, lat_cnt, iter_cnt and proto_err SHALL be unaffected, so an in-flight transaction still records correctly.
- If clear coincides with a done, the cleared values SHALL win.
REQ-026 rd_sel SHALL map counters as: 0 txn_count, 1 last_lat, 2 min_lat, 3 max_lat, 4 last_iter, 5 hold_cyc, 6 zero-extended {state, proto_err}, 7 zero.
REQ-027 rd_data SHALL be registered with 1-cycle latency; rd_ch>=NUM_CH SHALL read 0.
REQ-028 busy and all_idle SHALL be combinational decodes of the current FSM state.

Reset
REQ-029 While reset=0 at a rising edge, every channel SHALL go to IDLE.
REQ-030 While reset=0 at a rising edge, all counters SHALL be 0 except min_lat, which SHALL be all-ones.
REQ-031 While reset=0 at a rising edge, proto_err SHALL be 0 and rd_data SHALL be 0.
REQ-032 After reset, busy SHALL be 0 and all_idle SHALL be 1.
REQ-033 Reset asserted mid-transaction SHALL discard the in-flight transaction without recording it.

Verification
REQ-034 Single transaction: ch0 start at cycle 10, 3 iter_pulses, done at cycle 15 with continue=1 -> txn_count=1, last_lat=5, min_lat=max_lat=5, last_iter=3, busy[0] low from cycle 16.
REQ-035 Back-to-back: ch1 done+continue+start at the same cycle, second done 2 cycles later -> txn_count=2, last_lat=2, channel never in IDLE.
REQ-036 Continue stall: ch2 done with continue=0 for 4 cycles -> hold_cyc=4, second start ignored until continue rises, proto_err=0.
REQ-037 Protocol error: ap_done pulse on an idle channel -> proto_err set, txn_count unchanged, proto_err still set after clear.
REQ-038 Saturation/clear: CNT_W=8, 300 one-cycle transactions -> txn_count=255; clear during RUN -> next done gives txn_count=1 with correct latency.
REQ-039 Readout: rd_ch=7 with NUM_CH=4 -> rd_data=0 one cycle later; reset mid-RUN -> all_idle=1, min_lat all-ones.
